// File: rtl/rem_seq.sv
// rem_seq: sequential sign-magnitude remainder (restoring division, one bit per clock).
// Optional quotient output o_quot is enabled by defining REM_QUOT_EN.
`default_nettype none

module rem_seq #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  output logic [WIDTH-1:0] o_res,
`ifdef REM_QUOT_EN
  output logic [WIDTH-1:0] o_quot,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic             o_DZ,
  output logic             o_Z
);

  localparam int M  = WIDTH - 1;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic           r_sign;
  logic           r_dz;
  logic [M-1:0]   r_Q;
  logic [M-1:0]   r_R;
  logic [M-1:0]   r_absB;
  logic [CW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_res;
  logic           r_done;
  logic           r_DZ;
  logic           r_Z;
`ifdef REM_QUOT_EN
  logic [WIDTH-1:0] r_quot;
`endif

  logic           w_bz;
  logic [M:0]     w_T;
  logic           w_ge;
  logic [M-1:0]   w_diff;
  logic [M-1:0]   w_fmag;
  logic           w_fsign;

  assign w_bz   = (i_B[M-1:0] == '0);
  // The partial remainder's top bit is always 0 between iterations, so only
  // M bits are stored; the shifted value w_T carries the extra bit.
  assign w_T    = {r_R, r_Q[M-1]};
  assign w_ge   = (w_T >= {1'b0, r_absB});
  assign w_diff = w_T[M-1:0] - r_absB;
  // On the divide-by-zero path Q never shifts, so it still holds |A|.
  assign w_fmag  = r_dz ? r_Q : r_R;
  assign w_fsign = r_sign & (w_fmag != '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    o_busy = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: if (i_start) w_next = w_bz ? S_FIN : S_CALC;
      S_CALC: if (r_cnt == CW'(1)) w_next = S_FIN;
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sign <= 1'b0;
      r_dz   <= 1'b0;
      r_Q    <= '0;
      r_R    <= '0;
      r_absB <= '0;
      r_cnt  <= '0;
      r_res  <= '0;
      r_done <= 1'b0;
      r_DZ   <= 1'b0;
      r_Z    <= 1'b0;
`ifdef REM_QUOT_EN
      r_quot <= '0;
`endif
    end else begin
      r_done <= (r_state == S_FIN);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_sign <= i_A[M];
            r_Q    <= i_A[M-1:0];
            r_absB <= i_B[M-1:0];
            r_R    <= '0;
            r_cnt  <= CW'(M);
            r_dz   <= w_bz;
          end
        end
        S_CALC: begin
          r_R   <= w_ge ? w_diff : w_T[M-1:0];
          r_Q   <= {r_Q[M-2:0], w_ge};
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIN: begin
          r_res <= {w_fsign, w_fmag};
          r_DZ  <= r_dz;
          r_Z   <= (w_fmag == '0);
`ifdef REM_QUOT_EN
          r_quot <= r_dz ? '0 : {1'b0, r_Q};
`endif
        end
        default: ;
      endcase
    end
  end

  assign o_res  = r_res;
  assign o_done = r_done;
  assign o_DZ   = r_DZ;
  assign o_Z    = r_Z;
`ifdef REM_QUOT_EN
  assign o_quot = r_quot;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rem_seq.sv
// tb_rem_seq: scoreboard bench for rem_seq (WIDTH = 8); quotient checked when REM_QUOT_EN is defined.
`default_nettype none

module tb_rem_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_start = 1'b0;
  logic [W-1:0] i_A = '0;
  logic [W-1:0] i_B = '0;
  logic [W-1:0] o_res;
  logic         o_busy, o_done, o_DZ, o_Z;
`ifdef REM_QUOT_EN
  logic [W-1:0] o_quot;
`endif

  rem_seq #(.WIDTH(W)) u_dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (i_start),
    .i_A     (i_A),
    .i_B     (i_B),
    .o_res   (o_res),
`ifdef REM_QUOT_EN
    .o_quot  (o_quot),
`endif
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_DZ    (o_DZ),
    .o_Z     (o_Z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         dz;
    logic         z;
    logic [W-1:0] quot;
    int           cyc;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc_cyc);
    exp_t e;
    int ma, mb, r;
    ma = int'(a[W-2:0]);
    mb = int'(b[W-2:0]);
    if (mb == 0) begin
      e.res  = (ma == 0) ? '0 : a;
      e.dz   = 1'b1;
      e.z    = (ma == 0);
      e.quot = '0;
      e.cyc  = acc_cyc + 1;
    end else begin
      r      = ma % mb;
      e.res  = {(r != 0) ? a[W-1] : 1'b0, r[W-2:0]};
      e.dz   = 1'b0;
      e.z    = (r == 0);
      e.quot = W'(ma / mb);
      e.cyc  = acc_cyc + W;
    end
    return e;
  endfunction

  // Called at a falling edge; the following rising edge is the candidate accept edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    i_A = a;
    i_B = b;
    i_start = 1'b1;
    if (!o_busy) q_exp.push_back(model(a, b, cyc + 1));
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (o_done) seen = 1;
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (o_done) begin
      check("done_single_pulse", 32'(prev_done), 0);
      check("busy_in_done", 32'(o_busy), 0);
      if (q_exp.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = q_exp.pop_front();
        check("res", 32'(o_res), 32'(e.res));
        check("DZ", 32'(o_DZ), 32'(e.dz));
        check("Z", 32'(o_Z), 32'(e.z));
        check("latency", cyc, e.cyc);
`ifdef REM_QUOT_EN
        check("quot", 32'(o_quot), 32'(e.quot));
`endif
      end
    end
    prev_done <= o_done;
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_res", 32'(o_res), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_DZ", 32'(o_DZ), 0);
    check("rst_Z", 32'(o_Z), 0);
`ifdef REM_QUOT_EN
    check("rst_quot", 32'(o_quot), 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Directed cases: basic, dividend sign, exact division, divide by zero
    issue(8'h64, 8'h07); wait_done(20);
    check("basic_res_const", 32'(o_res), 32'h02);
    issue(8'hE4, 8'h87); wait_done(20);
    check("negA_res_const", 32'(o_res), 32'h82);
    issue(8'h64, 8'h87); wait_done(20);
    issue(8'h95, 8'h07); wait_done(20);
    check("exact_Z_const", 32'(o_Z), 1);
    issue(8'hA3, 8'h80); wait_done(5);
    check("dz_flag_const", 32'(o_DZ), 1);
    issue(8'h80, 8'h80); wait_done(5);

    // Start while busy is ignored; outputs hold until the next write
    issue(8'h64, 8'h07);
    repeat (2) @(negedge clk);
    issue(8'h05, 8'h03);
    check("hold_during_op", 32'(o_res), 32'h00);
    wait_done(20);

    // Back-to-back accept in the done cycle
    issue(8'h2D, 8'h05); wait_done(20);
    issue(8'h03, 8'h64); wait_done(20);
    issue(8'hC9, 8'h0B); wait_done(20);

    for (int k = 0; k < 8; k++) begin
      issue(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
      wait_done(20);
    end

    // Reset mid-operation
    issue(8'h64, 8'h07);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_res", 32'(o_res), 0);
    check("abort_busy", 32'(o_busy), 0);
    check("abort_DZ", 32'(o_DZ), 0);
    check("abort_Z", 32'(o_Z), 0);
    q_exp.delete();
    repeat (12) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue(8'hE4, 8'h07); wait_done(20);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", q_exp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
